jk_seq_ctrl: RTL and testbench
==============================

JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of JK cells in the sequenced bank.
REQ-002 SHALL have parameter CNTW, default 4: width of the COUNT step argument.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-007 SHALL have port cmd_op  input  2  operation: 00 LOAD, 01 TOGGLE, 10 COUNT, 11 CLEAR.
REQ-008 SHALL have port cmd_data  input  WIDTH  LOAD value or TOGGLE mask.
REQ-009 SHALL have port cmd_arg  input  CNTW  COUNT step count.
REQ-010 SHALL have port q  output  WIDTH  bank state.
REQ-011 SHALL have port q_bar  output  WIDTH  bitwise complement of q.
REQ-012 SHALL have port done  output  1  one-cycle pulse at command completion.

Function
REQ-013 SHALL hold bank state only in JK cells; the controller drives only per-cell J/K, never q directly.
REQ-014 SHALL implement FSM states IDLE, CLR, SET, TGL, CNT, DONE.
REQ-015 SHALL drive cmd_ready = 1 in IDLE only; a command is accepted on a rising edge with cmd_valid && cmd_ready, and cmd_data/cmd_arg are captured then.
REQ-016 SHALL drive J=K=0 (hold) on all cells in IDLE and DONE.
REQ-017 LOAD (accept at edge N): state CLR drives J=0,K=1 (q=0 at edge N+1); state SET drives J=data,K=~data (q=data at edge N+2); then DONE.
REQ-018 TOGGLE: state TGL drives J=K=mask; q ^= mask at edge N+1; then DONE.
REQ-019 CLEAR: reuses state CLR; q=0 at edge N+1; then DONE, not SET.
REQ-020 COUNT k: state CNT drives J=K=carry, with carry[0]=1 and carry[i]=&q[i-1:0]; q increments once per cycle at edges N+1..N+k; then DONE.
REQ-021 COUNT with k=0 SHALL spend one cycle in CNT with J=K=0, leaving q unchanged, then DONE.
REQ-022 COUNT past all-ones SHALL wrap to 0 (modulo 2^WIDTH) unless overridden by REQ-029.
REQ-023 done SHALL be 1 for exactly the single cycle spent in DONE; DONE returns to IDLE on the next edge.
REQ-024 cmd_valid outside IDLE SHALL be ignored (no queueing); cmd_valid may stay high across done.
REQ-025 q_bar SHALL equal ~q at all times, including during reset.

Reset
REQ-026 Asserting reset (low) at any time, including mid-command, SHALL immediately force q=0, q_bar=all ones, FSM=IDLE, done=0, and discard any captured command.
REQ-027 cmd_ready SHALL be 1 once the FSM is in IDLE, including while reset is held; the first accept occurs on the first rising edge after deassertion.

Configuration
REQ-028 Macro JK_SEQ_CNT_SAT_EN SHALL select COUNT overflow behaviour.
REQ-029 With JK_SEQ_CNT_SAT_EN defined: COUNT at q=all ones drives J=K=0 (q saturates) for the remaining steps; step timing and done timing are unchanged. Without it: COUNT wraps per REQ-022.

Structure
REQ-030 Package jk_seq_pkg SHALL hold the op encodings (LOAD/TOGGLE/COUNT/CLEAR) and the FSM state enum.
REQ-031 Sub-module jk_cell (1-bit JK flop: hold/reset/set/toggle for JK 00/01/10/11, async active-low reset to q=0) SHALL be instantiated WIDTH times.

Verification
REQ-032 LOAD 8'hA5 from q=8'h3C -> q=00 after edge N+1, A5 after N+2, done high in the following cycle only.
REQ-033 TOGGLE mask 8'hF0 on q=8'hA5 -> q=8'h55 after N+1; done one cycle; cmd_ready low from N to the DONE->IDLE edge.
REQ-034 COUNT k=3 from q=8'hFE -> q=FF, 00, 01 (without macro); with JK_SEQ_CNT_SAT_EN -> FF, FF, FF; done after edge N+3.
REQ-035 COUNT k=0 from q=8'h12 -> q stays 8'h12, done in the cycle after edge N+1.
REQ-036 Reset low during SET phase of LOAD 8'hFF -> q=00, q_bar=FF, done=0 immediately; a new CLEAR accepted on the first edge after release.
REQ-037 cmd_valid held high with varying ops -> exactly one command per IDLE visit; ops offered in non-IDLE states never take effect.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK bank sequencer: command op codes and FSM states.
package jk_seq_pkg;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_COUNT  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    SET  = 3'd2,
    TGL  = 3'd3,
    CNT  = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: JK 00 hold, 01 reset, 10 set, 11 toggle; async active-low reset to 0.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // next-state function of the JK cell
  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // cell state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer steering J/K of a bank of jk_cell flops (LOAD/TOGGLE/COUNT/CLEAR).
// Define JK_SEQ_CNT_SAT_EN to make COUNT saturate at all-ones instead of wrapping.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNTW-1:0]  cmd_arg,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             done_q, ready_q;
  logic [WIDTH-1:0] j_s, k_s, carry_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_s[i]),
      .k     (k_s[i]),
      .q     (q[i])
    );
  end

  assign q_bar     = ~q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

  // ripple carry mask for incrementing the bank: carry[i] = &q[i-1:0]
  always_comb begin
    carry_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry_s[i] = 1'b1;
      for (int b = 0; b < i; b++) begin
        carry_s[i] = carry_s[i] & q[b];
      end
    end
`ifdef JK_SEQ_CNT_SAT_EN
    if (&q) begin
      carry_s = '0;
    end else begin
      carry_s = carry_s;
    end
`endif
  end

  // FSM next state and per-cell J/K drive
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    j_s     = '0;
    k_s     = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d = cmd_data;
          cnt_d  = cmd_arg;
          case (cmd_op)
            OP_LOAD:   begin state_d = CLR; load_d = 1'b1; end
            OP_CLEAR:  begin state_d = CLR; load_d = 1'b0; end
            OP_TOGGLE: state_d = TGL;
            OP_COUNT:  state_d = CNT;
            default:   state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      CLR: begin
        k_s     = '1;
        state_d = load_q ? SET : DONE;
      end
      SET: begin
        j_s     = data_q;
        k_s     = ~data_q;
        state_d = DONE;
      end
      TGL: begin
        j_s     = data_q;
        k_s     = data_q;
        state_d = DONE;
      end
      CNT: begin
        // a zero step count still spends one idle cycle here
        if (cnt_q != {CNTW{1'b0}}) begin
          j_s   = carry_s;
          k_s   = carry_s;
          cnt_d = cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
        if (cnt_q <= {{(CNTW-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
        end else begin
          state_d = CNT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, captured command and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      done_q  <= (state_d == DONE);
      ready_q <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed self-checking bench for jk_seq_ctrl; honours JK_SEQ_CNT_SAT_EN for COUNT expectations.
module tb_jk_seq_ctrl;

  localparam logic [1:0] T_LOAD   = 2'b00;
  localparam logic [1:0] T_TOGGLE = 2'b01;
  localparam logic [1:0] T_COUNT  = 2'b10;
  localparam logic [1:0] T_CLEAR  = 2'b11;

`ifdef JK_SEQ_CNT_SAT_EN
  localparam logic [7:0] CNT_E2 = 8'hFF;
  localparam logic [7:0] CNT_E3 = 8'hFF;
`else
  localparam logic [7:0] CNT_E2 = 8'h00;
  localparam logic [7:0] CNT_E3 = 8'h01;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] cmd_arg = 4'h0;
  logic       cmd_ready;
  logic [7:0] q, q_bar;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jk_seq_ctrl #(.WIDTH(8), .CNTW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_arg   (cmd_arg),
    .q         (q),
    .q_bar     (q_bar),
    .done      (done)
  );

  // issue one command and wait (bounded) until it has completed and FSM is back in IDLE
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic [3:0] arg);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL run_cmd_timeout: done=%b required 1 within 40 cycles", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (q !== 8'h00 || q_bar !== 8'hFF) begin
      errors++; $display("FAIL reset_q: q=%h q_bar=%h required 00/FF", q, q_bar);
    end
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs: done=%b ready=%b required 0/1", done, cmd_ready);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    run_cmd(T_LOAD, 8'h3C, 4'h0);
    checks++;
    if (q !== 8'h3C) begin errors++; $display("FAIL load_pre: q=%h required 3C", q); end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = T_LOAD; cmd_data = 8'hA5;
    @(negedge clk);  // after edge N
    cmd_valid = 1'b0;
    checks++;
    if (q !== 8'h3C || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL load_n: q=%h ready=%b required 3C/0", q, cmd_ready);
    end
    @(negedge clk);  // after N+1
    checks++;
    if (q !== 8'h00 || done !== 1'b0) begin
      errors++; $display("FAIL load_n1: q=%h done=%b required 00/0", q, done);
    end
    @(negedge clk);  // after N+2
    checks++;
    if (q !== 8'hA5 || q_bar !== 8'h5A || done !== 1'b1) begin
      errors++; $display("FAIL load_n2: q=%h q_bar=%h done=%b required A5/5A/1", q, q_bar, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL load_end: done=%b ready=%b required 0/1", done, cmd_ready);
    end
  endtask

  task automatic test_toggle();
    cmd_valid = 1'b1; cmd_op = T_TOGGLE; cmd_data = 8'hF0;
    @(negedge clk);  // after N
    cmd_valid = 1'b0;
    checks++;
    if (q !== 8'hA5 || cmd_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL tgl_n: q=%h ready=%b done=%b required A5/0/0", q, cmd_ready, done);
    end
    @(negedge clk);  // after N+1
    checks++;
    if (q !== 8'h55 || done !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL tgl_n1: q=%h done=%b ready=%b required 55/1/0", q, done, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (q !== 8'h55 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL tgl_end: q=%h done=%b ready=%b required 55/0/1", q, done, cmd_ready);
    end
  endtask

  task automatic test_count();
    logic [7:0] exp_q [0:3];
    exp_q[0] = 8'hFE; exp_q[1] = 8'hFF; exp_q[2] = CNT_E2; exp_q[3] = CNT_E3;
    run_cmd(T_LOAD, 8'hFE, 4'h0);
    cmd_valid = 1'b1; cmd_op = T_COUNT; cmd_arg = 4'd3;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (q !== exp_q[s] || done !== (s == 3)) begin
        errors++; $display("FAIL cnt3_step%0d: q=%h done=%b required %h/%b", s, q, done, exp_q[s], (s == 3));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cnt3_end: done=%b ready=%b required 0/1", done, cmd_ready);
    end
    run_cmd(T_LOAD, 8'h0F, 4'h0);
    run_cmd(T_COUNT, 8'h00, 4'd5);
    checks++;
    if (q !== 8'h14) begin errors++; $display("FAIL cnt5: q=%h required 14", q); end
  endtask

  task automatic test_count_zero();
    run_cmd(T_LOAD, 8'h12, 4'h0);
    cmd_valid = 1'b1; cmd_op = T_COUNT; cmd_arg = 4'd0;
    @(negedge clk);  // after N
    cmd_valid = 1'b0;
    checks++;
    if (q !== 8'h12 || done !== 1'b0) begin
      errors++; $display("FAIL cnt0_n: q=%h done=%b required 12/0", q, done);
    end
    @(negedge clk);  // after N+1
    checks++;
    if (q !== 8'h12 || done !== 1'b1) begin
      errors++; $display("FAIL cnt0_n1: q=%h done=%b required 12/1", q, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL cnt0_end: done=%b required 0", done); end
  endtask

  task automatic test_reset_mid();
    // reset during DONE of a toggle: q and done must drop immediately
    run_cmd(T_CLEAR, 8'h00, 4'h0);
    cmd_valid = 1'b1; cmd_op = T_TOGGLE; cmd_data = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);  // in DONE, q=FF
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || q_bar !== 8'hFF || done !== 1'b0) begin
      errors++; $display("FAIL rst_done: q=%h q_bar=%h done=%b required 00/FF/0", q, q_bar, done);
    end
    @(negedge clk);
    reset = 1'b1;
    // reset during SET of LOAD FF
    cmd_valid = 1'b1; cmd_op = T_LOAD; cmd_data = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);  // in SET
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || q_bar !== 8'hFF || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_set: q=%h q_bar=%h done=%b ready=%b required 00/FF/0/1", q, q_bar, done, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (q !== 8'h00 || done !== 1'b0) begin
      errors++; $display("FAIL rst_hold: q=%h done=%b required 00/0", q, done);
    end
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_op = T_CLEAR; cmd_data = 8'h00;
    @(negedge clk);  // first edge after release accepts CLEAR
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL clr_accept: ready=%b done=%b required 0/0", cmd_ready, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || q !== 8'h00) begin
      errors++; $display("FAIL clr_done: done=%b q=%h required 1/00", done, q);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    done_cnt = 0;
    cmd_valid = 1'b1; cmd_op = T_TOGGLE; cmd_data = 8'h01;
    @(negedge clk);  // TGL; offer LOAD AA which must be ignored
    cmd_op = T_LOAD; cmd_data = 8'hAA;
    @(negedge clk);  // DONE, q=01; offer TOGGLE 02, ignored here, taken in IDLE
    checks++;
    if (q !== 8'h01 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_first: q=%h done=%b required 01/1", q, done);
    end
    cmd_op = T_TOGGLE; cmd_data = 8'h02;
    @(negedge clk);  // IDLE
    checks++;
    if (q !== 8'h01 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle: q=%h ready=%b required 01/1", q, cmd_ready);
    end
    @(negedge clk);  // TGL for mask 02; offer COUNT 5, ignored
    cmd_op = T_COUNT; cmd_arg = 4'd5;
    @(negedge clk);
    if (done) done_cnt++;
    cmd_valid = 1'b0;
    checks++;
    if (q !== 8'h03 || done_cnt !== 1) begin
      errors++; $display("FAIL b2b_second: q=%h done_seen=%0d required 03/1", q, done_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q !== 8'h03 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_end: q=%h ready=%b done=%b required 03/1/0", q, cmd_ready, done);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_toggle();
    test_count();
    test_count_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
